uart_send_bcd_frame: RTL
========================

Name: uart_send_bcd_frame

Overview:
- Parametrised successor of the fixed 3-digit temperature sender.
- Snapshots a DIGITS-wide packed BCD value plus a sign flag and formats it as an ASCII text frame: optional '-', digits with a configurable decimal point, and an LF or CRLF terminator.
- Streams the frame one byte at a time into the existing UART transmitter through the uart_en/uart_din/uart_tx_busy handshake.
- Frames start either on a single-shot request or periodically; sits between the sensor BCD converter and uart_tx.

Parameters:
- CLK_FREQ, 12_000_000: sys_clk frequency in Hz.
- DIGITS, 3: number of BCD digits, 1..8.
- DP_POS, 1: digits after the decimal point; 0 = no point emitted; must be < DIGITS.
- PERIOD_MS, 1000: auto-mode frame period in ms, 1..10000.
- CRLF, 0: 0 = terminator "\n" (0x0A); 1 = "\r\n" (0x0D 0x0A).
- LZ_SUPPRESS, 1: 1 = suppress leading zeros.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous reset, active low.
- start  in  1  single-cycle pulse; requests one frame.
- auto_en  in  1  level; 1 = send a frame every PERIOD_MS.
- bcd_in  in  4*DIGITS  packed BCD, most significant digit in the top nibble.
- neg  in  1  1 = value negative; emit '-'.
- uart_tx_busy  in  1  transmitter busy.
- uart_en  out  1  one-cycle send strobe.
- uart_din  out  8  byte to send; valid when uart_en=1.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last byte completes.

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE, uart_en=0, uart_din=0, busy=0, frame_done=0, period counter=0, char index=0, snapshot registers=0. Deasserting reset mid-frame abandons the frame; no partial resume.
- Trigger, IDLE only:
  - start=1, or auto_en=1 with period tick pending, causes LOAD on the next edge.
  - start while busy=1 is ignored (not queued).
  - Period tick: free-running counter of CLK_FREQ/1000*PERIOD_MS cycles, counts only while auto_en=1, clears when auto_en=0.
  - A tick arriving while busy is held pending until IDLE; multiple ticks collapse into one.
- LOAD (1 cycle): capture bcd_in and neg into snapshot registers, busy=1, char index=0. Input changes after LOAD do not affect the frame.
- Frame byte order:
  - '-' (0x2D) if neg.
  - Digits MSB-first as {4'h3, nibble}.
  - '.' (0x2E) inserted before the last DP_POS digits.
  - Terminator.
- Leading-zero suppression (LZ_SUPPRESS=1): zero digits are skipped until the first non-zero digit. The digit immediately left of '.' (or the last digit when DP_POS=0) is never suppressed. Examples: 007 with DP_POS=1 -> "0.7"; value 000 -> "0.0".
- Invalid nibble (>9) is sent as '?' (0x3F) and counts as non-zero for suppression.
- Handshake per byte, states SEND -> ACK -> WAIT:
  - SEND: when uart_tx_busy=0, drive uart_din and uart_en=1 for exactly one cycle, go to ACK. uart_din holds its value until the next byte.
  - ACK: wait for uart_tx_busy=1.
  - WAIT: wait for uart_tx_busy=0, then go to NEXT.
  - ACK timeout: if busy has not risen within 4 cycles, treat the byte as sent and go to NEXT.
- NEXT (1 cycle): compute the next byte or, after the terminator, go to DONE.
- DONE: frame_done=1 for one cycle, busy=0, return to IDLE.
- Auto mode: the period is measured start-to-start. If a frame outlasts the period, the next frame starts immediately after DONE.
- Maximum frame length is DIGITS+4 bytes; the char index width is $clog2(DIGITS+5).

Decomposition:
- Package uart_fmt_pkg: state encoding (IDLE, LOAD, NEXT, SEND, ACK, WAIT, DONE), ASCII constants (0x2D, 0x2E, 0x3F, 0x0D, 0x0A, 0x30), ACK_TIMEOUT=4.
- Sub-module bcd_ascii_fmt (combinational): from snapshot, neg and char index, outputs the byte and a last flag. Keeps the FSM generic.

Test Plan:
- DIGITS=3, DP_POS=1, CRLF=0, bcd_in=12'h257, neg=0, start pulse -> bytes 0x32 0x35 0x2E 0x37 0x0A; frame_done once; exactly one uart_en per byte.
- Same parameters, bcd_in=12'h007, neg=1 -> 0x2D 0x30 0x2E 0x37 0x0A. With LZ_SUPPRESS=0 -> 0x2D 0x30 0x30 0x2E 0x37 0x0A.
- CRLF=1, bcd_in=12'h1A0 -> 0x31 0x3F 0x2E 0x30 0x0D 0x0A.
- Transmitter model holds busy 20 cycles per byte; change bcd_in mid-frame; pulse start mid-frame -> frame uses the LOAD-time value; no second frame starts.
- auto_en=1, PERIOD_MS=1 at CLK_FREQ=12_000_000 -> frame starts spaced exactly 12000 cycles apart. Drop auto_en -> no further frames.
- Assert sys_rst_n=0 during WAIT -> all outputs go to 0 immediately. After release with start -> a complete fresh frame.

Source files
------------

// File: rtl/uart_fmt_pkg.sv
// ---------------------------------------------------------------------------
// uart_fmt_pkg
// Shared definitions for the BCD-to-ASCII UART frame sender:
//   - state_t      : frame sequencer state encoding
//   - ASCII_*      : byte constants used when building a frame
//   - ACK_TIMEOUT  : cycles to wait for the transmitter to report busy
//   - digit_char() : BCD nibble to ASCII digit ('?' for nibbles above 9)
// ---------------------------------------------------------------------------
package uart_fmt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_NEXT,
        ST_SEND,
        ST_ACK,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam int ACK_TIMEOUT = 4;

    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        return (nib > 4'd9) ? ASCII_QMARK : (ASCII_ZERO | {4'h0, nib});
    endfunction

endpackage

// File: rtl/bcd_ascii_fmt.sv
// ---------------------------------------------------------------------------
// bcd_ascii_fmt
// Combinational frame formatter. Given the captured BCD value, sign flag and
// a byte index, returns the byte at that position of the text frame and
// flags the final terminator byte.
// Ports:
//   snap_bcd  in  4*DIGITS  packed BCD, MS digit in the top nibble
//   snap_neg  in  1         emit a leading '-'
//   char_idx  in  IDX_W     position within the frame
//   char_out  out 8         byte at char_idx
//   is_last   out 1         char_idx addresses the final LF
// ---------------------------------------------------------------------------
module bcd_ascii_fmt
    import uart_fmt_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter int DP_POS      = 1,
    parameter int CRLF        = 0,
    parameter int LZ_SUPPRESS = 1,
    parameter int IDX_W       = 3
) (
    input  logic [4*DIGITS-1:0] snap_bcd,
    input  logic                snap_neg,
    input  logic [IDX_W-1:0]    char_idx,
    output logic [7:0]          char_out,
    output logic                is_last
);

    // Walk every candidate byte of the frame in order; pos counts the bytes
    // actually emitted so far, so the candidate whose pos equals char_idx is
    // the one selected. Suppressed leading zeros simply do not advance pos.
    always_comb begin : p_fmt
        logic [IDX_W-1:0] pos;
        logic             lead;
        char_out = ASCII_LF;
        is_last  = 1'b0;
        pos      = '0;
        lead     = (LZ_SUPPRESS != 0);

        if (snap_neg) begin
            if (pos == char_idx) char_out = ASCII_MINUS;
            pos = pos + IDX_W'(1);
        end

        for (int d = DIGITS - 1; d >= 0; d--) begin
            if (DP_POS > 0 && d == DP_POS - 1) begin
                if (pos == char_idx) char_out = ASCII_DOT;
                pos = pos + IDX_W'(1);
            end
            // Index DP_POS is the digit just left of the point (or the last
            // digit when there is no point); it and everything right of it
            // always print. Invalid nibbles are non-zero and end suppression.
            if (snap_bcd[4*d +: 4] != 4'h0 || d <= DP_POS) lead = 1'b0;
            if (!lead) begin
                if (pos == char_idx) char_out = digit_char(snap_bcd[4*d +: 4]);
                pos = pos + IDX_W'(1);
            end
        end

        if (CRLF != 0) begin
            if (pos == char_idx) char_out = ASCII_CR;
            pos = pos + IDX_W'(1);
        end

        if (pos == char_idx) begin
            char_out = ASCII_LF;
            is_last  = 1'b1;
        end
    end

endmodule

// File: rtl/uart_send_bcd_frame.sv
// ---------------------------------------------------------------------------
// uart_send_bcd_frame
// Captures a packed BCD value and sign, formats it as an ASCII line
// ("-", digits, optional decimal point, LF or CRLF) and streams it byte by
// byte into uart_tx. Frames start on a start pulse or every PERIOD_MS while
// auto_en is high.
// Ports:
//   sys_clk       in   system clock
//   sys_rst_n     in   asynchronous reset, active low
//   start         in   single-cycle frame request (ignored while busy)
//   auto_en       in   periodic frame enable
//   bcd_in        in   4*DIGITS packed BCD, MS digit in the top nibble
//   neg           in   value is negative
//   uart_tx_busy  in   transmitter busy
//   uart_en       out  one-cycle send strobe
//   uart_din      out  byte to send, held until the next byte
//   busy          out  frame in progress
//   frame_done    out  one-cycle pulse after the last byte
// ---------------------------------------------------------------------------
module uart_send_bcd_frame
    import uart_fmt_pkg::*;
#(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int DIGITS      = 3,
    parameter int DP_POS      = 1,
    parameter int PERIOD_MS   = 1000,
    parameter int CRLF        = 0,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic                auto_en,
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic                neg,
    input  logic                uart_tx_busy,
    output logic                uart_en,
    output logic [7:0]          uart_din,
    output logic                busy,
    output logic                frame_done
);

    localparam int IDX_W      = $clog2(DIGITS + 5);
    localparam int PERIOD_CYC = CLK_FREQ / 1000 * PERIOD_MS;
    localparam int PCNT_W     = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

    state_t                state;
    state_t                state_nxt;
    logic [PCNT_W-1:0]     per_cnt;
    logic                  tick;
    logic                  tick_pend;
    logic [4*DIGITS-1:0]   snap_bcd;
    logic                  snap_neg;
    logic [IDX_W-1:0]      char_idx;
    logic [2:0]            ack_cnt;
    logic [7:0]            fmt_char;
    logic                  fmt_last;

    bcd_ascii_fmt #(
        .DIGITS      (DIGITS),
        .DP_POS      (DP_POS),
        .CRLF        (CRLF),
        .LZ_SUPPRESS (LZ_SUPPRESS),
        .IDX_W       (IDX_W)
    ) u_fmt (
        .snap_bcd (snap_bcd),
        .snap_neg (snap_neg),
        .char_idx (char_idx),
        .char_out (fmt_char),
        .is_last  (fmt_last)
    );

    // Free-running period counter; the tick is latched so a tick landing
    // mid-frame fires once the sequencer is back in IDLE (start-to-start).
    assign tick = auto_en && (per_cnt == PCNT_W'(PERIOD_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            per_cnt   <= '0;
            tick_pend <= 1'b0;
        end else if (!auto_en) begin
            per_cnt   <= '0;
            tick_pend <= 1'b0;
        end else begin
            per_cnt <= tick ? '0 : per_cnt + PCNT_W'(1);
            if (tick)                  tick_pend <= 1'b1;
            else if (state == ST_LOAD) tick_pend <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start || (auto_en && tick_pend)) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (!uart_tx_busy) state_nxt = ST_ACK;
            // A transmitter that never reports busy must not hang the frame.
            ST_ACK: begin
                if (uart_tx_busy)                           state_nxt = ST_WAIT;
                else if (ack_cnt == 3'(ACK_TIMEOUT - 1))    state_nxt = ST_NEXT;
            end
            ST_WAIT: if (!uart_tx_busy) state_nxt = ST_NEXT;
            ST_NEXT: state_nxt = fmt_last ? ST_DONE : ST_SEND;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != ST_IDLE) && (state != ST_DONE);
        frame_done = (state == ST_DONE);
    end

    // Snapshot, byte index and the registered send strobe / data byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            snap_bcd <= '0;
            snap_neg <= 1'b0;
            char_idx <= '0;
            ack_cnt  <= '0;
            uart_en  <= 1'b0;
            uart_din <= 8'h00;
        end else begin
            uart_en <= 1'b0;
            case (state)
                ST_LOAD: begin
                    snap_bcd <= bcd_in;
                    snap_neg <= neg;
                    char_idx <= '0;
                end
                ST_SEND: begin
                    if (!uart_tx_busy) begin
                        uart_en  <= 1'b1;
                        uart_din <= fmt_char;
                        ack_cnt  <= '0;
                    end
                end
                ST_ACK:  ack_cnt <= ack_cnt + 3'd1;
                ST_NEXT: if (!fmt_last) char_idx <= char_idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

endmodule
